// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: data width, fetch FSM states, NOP encoding and buffer entry layout.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer with flush; a push in the flush cycle lands as the sole entry.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned      WIDTH      = 2 * XLEN,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [1:0]       count_nxt_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   assign full_o      = (count_q == 2'd2);
   assign empty_o     = (count_q == 2'd0);
   assign rdata_o     = mem_q[rd_ptr_q];
   assign count_nxt_o = count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push_i & (~full_o | pop_i);
      do_pop   = pop_i & ~empty_o;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = push_i;
         count_d  = {1'b0, push_i};
         if (push_i) begin
            mem_d[0] = wdata_i;
         end
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = 2'(count_q + {1'b0, do_push} - {1'b0, do_pop});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= RESET_DATA;
         mem_q[1] <= RESET_DATA;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited requests, in-order response buffering, redirect flush.
// Optional IF_MISALIGN_CHECK_EN turns misaligned redirect targets into a flagged NOP and halts fetch.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic            if_misaligned
`endif
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [1:0]      outst_q, outst_d;
   logic [1:0]      drop_q, drop_d;
   logic            req_valid_q, req_valid_d;
   logic [1:0]      occ_nxt;
   logic            accept, rsp_cnt;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic            redirect_misal, fetch_halt_d;
   logic [XLEN-1:0] rsp_pc, redirect_tgt;
   fetch_entry_t    wr_entry, head;

   assign accept       = req_valid_q & imem_req_ready;
   assign rsp_cnt      = imem_rsp_valid & ((outst_q != 2'd0) | accept);
   // In FETCH every outstanding request is live and sequential, so the oldest one sits outst_q words back.
   assign rsp_pc       = pc_q - XLEN'({outst_q, 2'b00});
   assign redirect_tgt = redirect_pc & ~XLEN'(3);
   assign fifo_pop     = ~fifo_empty & if_ready;
   assign fifo_push    = (imem_rsp_valid & (state_q == FETCH) & ~redirect_valid & (~fifo_full | fifo_pop))
                         | redirect_misal;

   always_comb begin
      wr_entry.pc    = rsp_pc;
      wr_entry.instr = imem_rsp_data;
      if (redirect_misal) begin
         wr_entry.pc    = redirect_pc;
         wr_entry.instr = NOP;
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   logic halt_q, halt_d;

   assign redirect_misal = redirect_valid & (redirect_pc[1:0] != 2'b00);
   assign halt_d         = redirect_valid ? redirect_misal : halt_q;
   assign fetch_halt_d   = halt_d;
   assign if_misaligned  = halt_q & ~fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt_q <= 1'b0;
      end else begin
         halt_q <= halt_d;
      end
   end
`else
   assign redirect_misal = 1'b0;
   assign fetch_halt_d   = 1'b0;
`endif

   fetch_fifo #(
      .WIDTH      (2 * XLEN),
      .RESET_DATA ({RESET_PC, {XLEN{1'b0}}})
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .pop_i       (fifo_pop),
      .flush_i     (redirect_valid),
      .wdata_i     (wr_entry),
      .rdata_o     (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_nxt_o (occ_nxt)
   );

   // Next-state: PC, in-flight count, stale-response drop count, FETCH/FLUSH.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      outst_d = 2'(outst_q + {1'b0, accept} - {1'b0, rsp_cnt});
      unique case (state_q)
         FETCH: begin
            if (accept) begin
               pc_d = pc_q + XLEN'(4);
            end
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               drop_d  = outst_d;
               state_d = (outst_d != 2'd0) ? FLUSH : FETCH;
            end
         end
         FLUSH: begin
            if (rsp_cnt && (drop_q != 2'd0)) begin
               drop_d = drop_q - 2'd1;
            end
            if (redirect_valid) begin
               pc_d = redirect_tgt;
            end
            if (drop_d == 2'd0) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      req_valid_d = (state_d == FETCH) & ~fetch_halt_d
                    & ((3'(occ_nxt) + 3'(outst_d)) < 3'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         outst_q     <= 2'd0;
         drop_q      <= 2'd0;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         outst_q     <= outst_d;
         drop_q      <= drop_d;
         req_valid_q <= req_valid_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign if_valid       = ~fifo_empty;
   assign if_instr       = head.instr;
   assign if_pc          = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios push expected fetch stream, a monitor compares.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef IF_MISALIGN_CHECK_EN
   logic        if_misaligned;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_if_pc[$];
   logic [31:0] exp_if_instr[$];
   logic [31:0] exp_req[$];
   logic [31:0] pend[$];
   logic        mem_rdy = 1'b1;
   logic        rsp_en  = 1'b1;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
`ifdef IF_MISALIGN_CHECK_EN
      ,
      .if_misaligned  (if_misaligned)
`endif
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0003;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic exp_fetch(input logic [31:0] pc);
      exp_if_pc.push_back(pc);
      exp_if_instr.push_back(instr_of(pc));
   endtask

   task automatic exp_seq(input logic [31:0] base, input int n, input bit with_req);
      for (int i = 0; i < n; i++) begin
         exp_fetch(base + 32'(4 * i));
         if (with_req) exp_req.push_back(base + 32'(4 * i));
      end
   endtask

   // One clock cycle of memory behaviour, driven at the negedge that opens the cycle.
   task automatic cycle();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (rsp_en && pend.size() != 0) begin
         logic [31:0] a;
         a = pend.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(a);
      end
      imem_req_ready = mem_rdy;
      if (imem_req_valid && mem_rdy) pend.push_back(imem_req_addr);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if_ready       = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      mem_rdy        = 1'b1;
      rsp_en         = 1'b1;
      pend.delete();
      repeat (2) @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_if_valid", 32'(if_valid), 32'h0);
      check("rst_if_pc", if_pc, RST_PC);
      check("rst_if_instr", if_instr, 32'h0);
      rst = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while (exp_if_pc.size() != 0 && k < budget) begin
         cycle();
         k++;
      end
      checks++;
      if (exp_if_pc.size() != 0) begin
         failures++;
         $display("FAIL %s_drain pending=%0d expected=0 after %0d cycles", name, exp_if_pc.size(), budget);
         exp_if_pc.delete();
         exp_if_instr.delete();
      end
      if_ready = 1'b0;
      check({name, "_req_left"}, 32'(exp_req.size()), 32'h0);
      exp_req.delete();
   endtask

   // Monitor: compares decode handshakes and accepted request addresses against expectations.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (if_valid && if_ready) begin
               if (exp_if_pc.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_instr actual_pc=%h expected=none", if_pc);
               end else begin
                  check("if_pc", if_pc, exp_if_pc.pop_front());
                  check("if_instr", if_instr, exp_if_instr.pop_front());
               end
            end
            if (imem_req_valid && imem_req_ready && exp_req.size() != 0) begin
               check("req_addr", imem_req_addr, exp_req.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and sequential fetch from RESET_PC
      do_reset();
      if_ready = 1'b1;
      exp_seq(RST_PC, 6, 1'b1);
      cycle();
      check("first_req_valid", 32'(imem_req_valid), 32'h1);
      check("first_req_addr", imem_req_addr, RST_PC);
      drain("t1", 80);

      // Backpressure: two buffered instructions stop further requests
      do_reset();
      exp_req.push_back(32'h100);
      exp_req.push_back(32'h104);
      repeat (6) cycle();
      check("bp_req_valid", 32'(imem_req_valid), 32'h0);
      check("bp_if_valid", 32'(if_valid), 32'h1);
      check("bp_if_pc", if_pc, 32'h100);
      check("bp_if_instr", if_instr, instr_of(32'h100));
      exp_seq(32'h100, 6, 1'b0);
      for (int i = 2; i < 6; i++) exp_req.push_back(32'h100 + 32'(4 * i));
      if_ready = 1'b1;
      drain("t2", 80);

      // Redirect with two requests in flight
      do_reset();
      if_ready = 1'b1;
      rsp_en   = 1'b0;
      exp_req.push_back(32'h100);
      exp_req.push_back(32'h104);
      repeat (4) cycle();
      check("rd2_stall", 32'(imem_req_valid), 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      cycle();
      redirect_valid = 1'b0;
      rsp_en         = 1'b1;
      check("rd2_if_valid", 32'(if_valid), 32'h0);
      check("rd2_flush_req", 32'(imem_req_valid), 32'h0);
      exp_seq(32'h200, 3, 1'b1);
      drain("t3", 80);

      // Redirect coinciding with a response and a decode handshake
      do_reset();
      exp_req.push_back(32'h100);
      exp_req.push_back(32'h104);
      repeat (3) cycle();
      check("co_if_valid", 32'(if_valid), 32'h1);
      check("co_if_pc", if_pc, 32'h100);
      exp_fetch(32'h100);
      exp_seq(32'h300, 3, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      if_ready       = 1'b1;
      cycle();
      redirect_valid = 1'b0;
      check("co_after_if_valid", 32'(if_valid), 32'h0);
      drain("t4", 80);

      // PC wrap at the top of the address space
      do_reset();
      mem_rdy = 1'b0;
      repeat (3) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      cycle();
      redirect_valid = 1'b0;
      mem_rdy        = 1'b1;
      if_ready       = 1'b1;
      check("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
      exp_seq(32'hFFFF_FFF8, 4, 1'b1);
      drain("t5", 80);

`ifdef IF_MISALIGN_CHECK_EN
      // Misaligned redirect: flagged NOP, fetch halted until the next redirect
      do_reset();
      mem_rdy = 1'b0;
      repeat (3) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h202;
      cycle();
      redirect_valid = 1'b0;
      mem_rdy        = 1'b1;
      check("mis_flag", 32'(if_misaligned), 32'h1);
      check("mis_if_pc", if_pc, 32'h202);
      check("mis_if_instr", if_instr, 32'h0000_0013);
      check("mis_req_valid", 32'(imem_req_valid), 32'h0);
      repeat (4) cycle();
      check("mis_still_halted", 32'(imem_req_valid), 32'h0);
      check("mis_pending", 32'(pend.size()), 32'h0);
      exp_if_pc.push_back(32'h202);
      exp_if_instr.push_back(32'h0000_0013);
      if_ready = 1'b1;
      drain("t6a", 10);
      exp_seq(32'h500, 2, 1'b1);
      if_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h500;
      cycle();
      redirect_valid = 1'b0;
      drain("t6b", 40);
`else
      // Low redirect target bits are ignored for the fetch address
      do_reset();
      mem_rdy = 1'b0;
      repeat (3) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h403;
      cycle();
      redirect_valid = 1'b0;
      mem_rdy        = 1'b1;
      if_ready       = 1'b1;
      check("align_addr", imem_req_addr, 32'h400);
      exp_seq(32'h400, 2, 1'b1);
      drain("t6", 40);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  the only clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_rsp_valid  input  1  instruction returned; responses arrive in request order, one per cycle maximum.
REQ-008 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken; one-cycle pulse.
REQ-010 SHALL have port redirect_pc  input  32  new fetch target.
REQ-011 SHALL have port if_valid  output  1  instruction available to decode/immediate generation.
REQ-012 SHALL have port if_ready  input  1  decode consumes the instruction.
REQ-013 SHALL have port if_instr  output  32  instruction word.
REQ-014 SHALL have port if_pc  output  32  address of if_instr.

Function
REQ-015 SHALL hold a 2-entry instruction buffer of {pc, instr}; if_valid = buffer non-empty, if_instr/if_pc = head entry.
REQ-016 SHALL issue imem_req_valid only when (buffer occupancy + outstanding requests) < 2 and state is FETCH.
REQ-017 SHALL advance fetch PC by 4 and increment outstanding on each accepted request (imem_req_valid & imem_req_ready); PC wraps 32'hFFFF_FFFC -> 32'h0.
REQ-018 SHALL push each non-discarded response into the buffer with its request PC, decrementing outstanding; latency from response to if_valid is one cycle.
REQ-019 SHALL pop the head on if_valid & if_ready; simultaneous push and pop at any occupancy SHALL preserve order and occupancy.
REQ-020 SHALL implement states FETCH and FLUSH; FETCH -> FLUSH on redirect_valid when outstanding (including a request accepted that cycle) is non-zero; FETCH -> FETCH on redirect with none outstanding.
REQ-021 SHALL on redirect_valid: load fetch PC with redirect_pc, empty the buffer, set drop count to outstanding; if_valid is 0 the following cycle.
REQ-022 SHALL in FLUSH discard every response and decrement drop count, issue no requests, and return to FETCH when drop count reaches 0.
REQ-023 SHALL treat a response arriving in the same cycle as redirect_valid as discarded.
REQ-024 SHALL let a decode handshake in the redirect cycle complete; the flushed buffer takes precedence for the next cycle.
REQ-025 SHALL accept a redirect in FLUSH: update PC, keep drop count, remain in FLUSH.
REQ-026 SHALL ignore redirect_pc[1:0] for the fetch address (forced 2'b00).

Reset
REQ-027 SHALL on rst asynchronously set fetch PC = RESET_PC, buffer empty, outstanding = 0, drop count = 0, state = FETCH; imem_req_valid = 0, if_valid = 0, if_instr = 32'h0, if_pc = RESET_PC.
REQ-028 SHALL begin requesting in the first cycle after rst deasserts; reset mid-operation SHALL abandon outstanding requests without tracking them.

Configuration
REQ-029 SHALL with IF_MISALIGN_CHECK_EN defined add output if_misaligned (1 bit): a redirect with redirect_pc[1:0] != 0 places one entry {redirect_pc, 32'h0000_0013} flagged misaligned in the buffer and halts fetching until the next redirect.
REQ-030 SHALL without IF_MISALIGN_CHECK_EN omit if_misaligned and apply REQ-026 only.

Structure
REQ-031 SHALL place XLEN (32), the fetch-state enum, and NOP constant 32'h0000_0013 in shared package riscv_pkg.
REQ-032 SHALL implement the buffer as sub-module fetch_fifo (depth 2, width 64, push/pop/flush, full/empty).

Verification
REQ-033 SHALL cover reset: RESET_PC=32'h0000_0100, rst released, ready memory latency 1 -> addresses 0x100, 0x104, 0x108; if_pc 0x100 first.
REQ-034 SHALL cover backpressure: if_ready=0 -> after two responses no imem_req_valid; if_ready=1 -> requests resume, no instruction lost or duplicated.
REQ-035 SHALL cover redirect with two outstanding: redirect_pc=0x200 -> two stale responses dropped, next if_pc = 0x200.
REQ-036 SHALL cover redirect coincident with response and with decode handshake -> response dropped, handshaken instruction consumed once.
REQ-037 SHALL cover wrap: PC 0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-038 SHALL cover IF_MISALIGN_CHECK_EN: redirect_pc=0x202 -> if_misaligned=1, if_pc=0x202, no further requests until redirect.
